// File: rtl/datapath_sequencer.sv
// Datapath control sequencer: accepts one instruction per handshake and issues bus micro-ops.
// Optional stall input enabled by defining SEQ_STALL_EN.
module datapath_sequencer #(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 5,
    parameter int FUNC_W    = 5,
    parameter int LAST_FUNC = 13
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef SEQ_STALL_EN
    input  logic                 stall,
`endif
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic [FUNC_W-1:0]    alu_function_sel,
    output logic                 alu_store_1,
    output logic                 alu_store_2,
    output logic                 alu_broadcast,
    output logic [REG_IDX_W-1:0] register_index,
    output logic                 register_read_enable,
    output logic                 register_write_enable,
    output logic [DATA_W-1:0]    imm,
    output logic                 imm_EN,
    output logic                 done,
    output logic                 illegal_instr
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_A    = 3'd1,
        LOAD_B    = 3'd2,
        EXEC      = 3'd3,
        WRITE_IMM = 3'd4
    } state_t;

    localparam logic [FUNC_W-1:0] LAST_FUNC_L = FUNC_W'(LAST_FUNC);

    state_t      state_reg, state_next;
    logic [31:0] instr_reg;
    logic        illegal_reg;
    logic        stall_int;
    logic        transfer;
    logic        legal_in;

`ifdef SEQ_STALL_EN
    assign stall_int = stall;
`else
    assign stall_int = 1'b0;
`endif

    // Legality is judged on the incoming word so an illegal one never leaves IDLE.
    assign legal_in = (instr[31:30] == 2'b10) ||
                      ((instr[31:30] != 2'b11) && (instr[29:25] <= LAST_FUNC_L));
    assign transfer = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            instr_reg   <= '0;
            illegal_reg <= 1'b0;
        end else if (!stall_int) begin
            state_reg   <= state_next;
            illegal_reg <= transfer && !legal_in;
            if (transfer) begin
                instr_reg <= instr;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (transfer && legal_in) begin
                    state_next = (instr[31:30] == 2'b10) ? WRITE_IMM : LOAD_A;
                end
            end
            LOAD_A:    state_next = LOAD_B;
            LOAD_B:    state_next = EXEC;
            EXEC:      state_next = IDLE;
            WRITE_IMM: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        instr_ready           = 1'b0;
        alu_function_sel      = '0;
        alu_store_1           = 1'b0;
        alu_store_2           = 1'b0;
        alu_broadcast         = 1'b0;
        register_index        = '0;
        register_read_enable  = 1'b0;
        register_write_enable = 1'b0;
        imm                   = '0;
        imm_EN                = 1'b0;
        done                  = 1'b0;
        illegal_instr         = illegal_reg;
        case (state_reg)
            IDLE: begin
                instr_ready = 1'b1;
            end
            LOAD_A: begin
                register_index       = instr_reg[19:15];
                register_read_enable = 1'b1;
                alu_store_1          = 1'b1;
            end
            LOAD_B: begin
                alu_store_2 = 1'b1;
                if (instr_reg[31:30] == 2'b01) begin
                    imm    = {{(DATA_W-15){1'b0}}, instr_reg[14:0]};
                    imm_EN = 1'b1;
                end else begin
                    register_index       = instr_reg[14:10];
                    register_read_enable = 1'b1;
                end
            end
            EXEC: begin
                alu_function_sel      = instr_reg[29:25];
                alu_broadcast         = 1'b1;
                register_index        = instr_reg[24:20];
                register_write_enable = 1'b1;
                done                  = 1'b1;
            end
            WRITE_IMM: begin
                imm                   = {{(DATA_W-20){1'b0}}, instr_reg[19:0]};
                imm_EN                = 1'b1;
                register_index        = instr_reg[24:20];
                register_write_enable = 1'b1;
                done                  = 1'b1;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
        // A stalled cycle keeps the bus driven but commits nothing.
        if (stall_int) begin
            instr_ready           = 1'b0;
            alu_store_1           = 1'b0;
            alu_store_2           = 1'b0;
            register_write_enable = 1'b0;
            done                  = 1'b0;
            illegal_instr         = 1'b0;
        end
    end

endmodule
